// File: rtl/pe_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// pe_cmd_sequencer
//   Issues the command stream for one PE job over a valid/ready handshake:
//   SET, LOAD_WGHT, then for each ifmap row LOAD_IFMAP, CONV and (optionally)
//   ACC. The layer configuration is latched on an accepted start and held on
//   the PE config pins until the next accepted start. After the last command
//   the block waits for the PE to report idle before pulsing o_done.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_start              job request (only looked at while idle)
//   i_layer_p/q/s        layer configuration (p filters, q channels, s width)
//   i_num_rows           number of ifmap rows N
//   i_acc_en             issue ACC after every CONV
//   o_layer_p/q/s        latched configuration driven to the PE
//   o_opcode             SET=000 LOAD_IFMAP=001 LOAD_WGHT=010 CONV=011 ACC=100
//   o_opcode_valid       command valid
//   i_opcode_ready       PE ready (high only while the PE is idle)
//   o_row_idx            row being issued
//   o_busy               job in progress
//   o_done               one-cycle pulse, job finished and PE idle
//   o_cfg_err            one-cycle pulse, start rejected (zero field)
// ---------------------------------------------------------------------------
module pe_cmd_sequencer #(
    parameter int ROW_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [4:0]           i_layer_p,
    input  logic [2:0]           i_layer_q,
    input  logic [3:0]           i_layer_s,
    input  logic [ROW_WIDTH-1:0] i_num_rows,
    input  logic                 i_acc_en,
    output logic [4:0]           o_layer_p,
    output logic [2:0]           o_layer_q,
    output logic [3:0]           o_layer_s,
    output logic [2:0]           o_opcode,
    output logic                 o_opcode_valid,
    input  logic                 i_opcode_ready,
    output logic [ROW_WIDTH-1:0] o_row_idx,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_WGHT  = 3'd2,
        S_IFMAP = 3'd3,
        S_CONV  = 3'd4,
        S_ACC   = 3'd5,
        S_DRAIN = 3'd6
    } state_t;

    localparam logic [2:0] OP_SET   = 3'b000;
    localparam logic [2:0] OP_IFMAP = 3'b001;
    localparam logic [2:0] OP_WGHT  = 3'b010;
    localparam logic [2:0] OP_CONV  = 3'b011;
    localparam logic [2:0] OP_ACC   = 3'b100;

    state_t               r_state;
    logic [ROW_WIDTH-1:0] r_num_rows;
    logic                 r_acc_en;
    logic                 r_drain_first;

    logic                 w_hs;
    logic                 w_cfg_ok;
    logic                 w_last_row;

    assign w_hs       = o_opcode_valid & i_opcode_ready;
    assign w_cfg_ok   = (i_layer_p != 5'd0) && (i_layer_q != 3'd0) &&
                        (i_layer_s != 4'd0) && (i_num_rows != '0);
    // N is never 0 inside a job, so N-1 cannot underflow; equality compare
    // means N = 2^ROW_WIDTH-1 finishes at row 2^ROW_WIDTH-2 without wrapping.
    assign w_last_row = (o_row_idx == (r_num_rows - ROW_WIDTH'(1)));

    // Command FSM with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_num_rows     <= '0;
            r_acc_en       <= 1'b0;
            r_drain_first  <= 1'b0;
            o_layer_p      <= 5'd0;
            o_layer_q      <= 3'd0;
            o_layer_s      <= 4'd0;
            o_opcode       <= OP_SET;
            o_opcode_valid <= 1'b0;
            o_row_idx      <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_cfg_err      <= 1'b0;
        end else begin
            o_done    <= 1'b0;
            o_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_cfg_ok) begin
                            o_layer_p      <= i_layer_p;
                            o_layer_q      <= i_layer_q;
                            o_layer_s      <= i_layer_s;
                            r_num_rows     <= i_num_rows;
                            r_acc_en       <= i_acc_en;
                            o_row_idx      <= '0;
                            o_opcode       <= OP_SET;
                            o_opcode_valid <= 1'b1;
                            o_busy         <= 1'b1;
                            r_state        <= S_SET;
                        end else begin
                            o_cfg_err <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SET: begin
                    if (w_hs) begin
                        o_opcode <= OP_WGHT;
                        r_state  <= S_WGHT;
                    end else begin
                        r_state <= S_SET;
                    end
                end
                S_WGHT: begin
                    if (w_hs) begin
                        o_opcode <= OP_IFMAP;
                        r_state  <= S_IFMAP;
                    end else begin
                        r_state <= S_WGHT;
                    end
                end
                S_IFMAP: begin
                    if (w_hs) begin
                        o_opcode <= OP_CONV;
                        r_state  <= S_CONV;
                    end else begin
                        r_state <= S_IFMAP;
                    end
                end
                S_CONV: begin
                    if (w_hs && r_acc_en) begin
                        o_opcode <= OP_ACC;
                        r_state  <= S_ACC;
                    end else if (w_hs && w_last_row) begin
                        o_opcode       <= OP_SET;
                        o_opcode_valid <= 1'b0;
                        r_drain_first  <= 1'b1;
                        r_state        <= S_DRAIN;
                    end else if (w_hs) begin
                        o_row_idx <= o_row_idx + ROW_WIDTH'(1);
                        o_opcode  <= OP_IFMAP;
                        r_state   <= S_IFMAP;
                    end else begin
                        r_state <= S_CONV;
                    end
                end
                S_ACC: begin
                    if (w_hs && w_last_row) begin
                        o_opcode       <= OP_SET;
                        o_opcode_valid <= 1'b0;
                        r_drain_first  <= 1'b1;
                        r_state        <= S_DRAIN;
                    end else if (w_hs) begin
                        o_row_idx <= o_row_idx + ROW_WIDTH'(1);
                        o_opcode  <= OP_IFMAP;
                        r_state   <= S_IFMAP;
                    end else begin
                        r_state <= S_ACC;
                    end
                end
                S_DRAIN: begin
                    // The PE drops ready one cycle after the final hs, so the
                    // first drain cycle still sees the stale ready.
                    if (r_drain_first) begin
                        r_drain_first <= 1'b0;
                    end else if (i_opcode_ready) begin
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                default: begin
                    o_opcode_valid <= 1'b0;
                    o_busy         <= 1'b0;
                    r_drain_first  <= 1'b0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_cmd_sequencer.sv
module tb_pe_cmd_sequencer;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [4:0] i_layer_p;
    logic [2:0] i_layer_q;
    logic [3:0] i_layer_s;
    logic [7:0] i_num_rows;
    logic       i_acc_en;
    logic [4:0] o_layer_p;
    logic [2:0] o_layer_q;
    logic [3:0] o_layer_s;
    logic [2:0] o_opcode;
    logic       o_opcode_valid;
    logic       i_opcode_ready;
    logic [7:0] o_row_idx;
    logic       o_busy;
    logic       o_done;
    logic       o_cfg_err;

    int checks = 0;
    int errors = 0;
    int last_p = 0;
    int last_q = 0;
    int last_s = 0;

    always #5 clk = ~clk;

    pe_cmd_sequencer #(.ROW_WIDTH(8)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
        .i_layer_p(i_layer_p), .i_layer_q(i_layer_q), .i_layer_s(i_layer_s),
        .i_num_rows(i_num_rows), .i_acc_en(i_acc_en),
        .o_layer_p(o_layer_p), .o_layer_q(o_layer_q), .o_layer_s(o_layer_s),
        .o_opcode(o_opcode), .o_opcode_valid(o_opcode_valid),
        .i_opcode_ready(i_opcode_ready), .o_row_idx(o_row_idx),
        .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready tied high; 1: PE busy 5 cycles after every hs; 2: random ready
    task automatic run_job(input int p, input int q, input int s, input int n,
                           input int acc, input int mode, input bit noise);
        logic [2:0] ops[$];
        int         rows[$];
        int         total;
        int         k = 0;
        int         d = 0;
        int         gap = 100;
        int         cyc = 0;
        int         bound;
        bit         done_next = 1'b0;
        bit         fin = 1'b0;
        logic       rdy;
        ops.push_back(3'b000); rows.push_back(0);
        ops.push_back(3'b010); rows.push_back(0);
        for (int r = 0; r < n; r++) begin
            ops.push_back(3'b001); rows.push_back(r);
            ops.push_back(3'b011); rows.push_back(r);
            if (acc != 0) begin
                ops.push_back(3'b100); rows.push_back(r);
            end
        end
        total = 2 + n * (2 + acc);
        bound = 20 * total + 100;
        @(negedge clk);
        i_start = 1'b1;
        i_layer_p = 5'(p); i_layer_q = 3'(q); i_layer_s = 4'(s);
        i_num_rows = 8'(n); i_acc_en = acc[0];
        i_opcode_ready = 1'b0;
        last_p = p; last_q = q; last_s = s;
        while (!fin && cyc < bound) begin
            @(negedge clk);
            cyc++;
            gap++;
            if (noise) begin
                i_start    = 1'($urandom_range(0, 1));
                i_layer_p  = 5'($urandom);
                i_layer_q  = 3'($urandom);
                i_layer_s  = 4'($urandom);
                i_num_rows = 8'($urandom);
                i_acc_en   = 1'($urandom_range(0, 1));
            end else begin
                i_start = 1'b0;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (gap > 5);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            i_opcode_ready = rdy;
            check("layer_p", o_layer_p, p);
            check("layer_q", o_layer_q, q);
            check("layer_s", o_layer_s, s);
            check("cfg_err", o_cfg_err, 0);
            if (done_next) begin
                i_start = 1'b0;
                check("done", o_done, 1);
                check("busy_end", o_busy, 0);
                check("valid_end", o_opcode_valid, 0);
                check("row_end", o_row_idx, n - 1);
                fin = 1'b1;
            end else begin
                check("busy", o_busy, 1);
                check("done_early", o_done, 0);
                check("valid", o_opcode_valid, (k < total) ? 1 : 0);
                if (k < total) begin
                    check("opcode", o_opcode, ops[k]);
                    check("row_idx", o_row_idx, rows[k]);
                    if (rdy) begin
                        k++;
                        gap = 0;
                    end
                end else begin
                    check("row_drain", o_row_idx, n - 1);
                    d++;
                    if (d >= 2 && rdy) done_next = 1'b1;
                end
            end
        end
        check("timeout", fin, 1);
        check("hs_count", k, total);
        @(negedge clk);
        check("done_pulse", o_done, 0);
        check("idle_valid", o_opcode_valid, 0);
        check("idle_busy", o_busy, 0);
    endtask

    initial begin
        int zf;
        i_rst = 1'b1; i_start = 1'b0; i_layer_p = 5'd0; i_layer_q = 3'd0;
        i_layer_s = 4'd0; i_num_rows = 8'd0; i_acc_en = 1'b0; i_opcode_ready = 1'b0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        check("rst_valid", o_opcode_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_cfg_err, 0);
        check("rst_row", o_row_idx, 0);
        check("rst_opcode", o_opcode, 0);
        check("rst_layer", {o_layer_p, o_layer_q, o_layer_s}, 0);

        // single row, ready tied high
        run_job(3, 2, 3, 1, 0, 0, 1'b0);
        // PE-like ready with accumulate
        run_job(5, 4, 7, 2, 1, 1, 1'b0);

        // rejected start: one zero field chosen at random
        @(negedge clk);
        zf = $urandom_range(0, 3);
        i_start = 1'b1;
        i_layer_p = (zf == 0) ? 5'd0 : 5'd9;
        i_layer_q = (zf == 1) ? 3'd0 : 3'd3;
        i_layer_s = (zf == 2) ? 4'd0 : 4'd2;
        i_num_rows = (zf == 3) ? 8'd0 : 8'd4;
        @(negedge clk);
        i_start = 1'b0;
        check("err_pulse", o_cfg_err, 1);
        check("err_busy", o_busy, 0);
        check("err_valid", o_opcode_valid, 0);
        check("err_layer_p", o_layer_p, last_p);
        check("err_layer_q", o_layer_q, last_q);
        @(negedge clk);
        check("err_once", o_cfg_err, 0);
        check("err_valid2", o_opcode_valid, 0);
        run_job(1, 1, 1, 3, 0, 2, 1'b0);

        // randomized jobs with start/config noise while busy
        for (int j = 0; j < 4; j++) begin
            run_job($urandom_range(1, 31), $urandom_range(1, 7), $urandom_range(1, 15),
                    $urandom_range(1, 6), $urandom_range(0, 1), 2, 1'b1);
        end

        // reset while CONV of row 1 waits with ready low
        @(negedge clk);
        i_start = 1'b1; i_layer_p = 5'd7; i_layer_q = 3'd5; i_layer_s = 4'd9;
        i_num_rows = 8'd3; i_acc_en = 1'b0; i_opcode_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (5) @(negedge clk);
        i_opcode_ready = 1'b0;
        check("pre_rst_op", o_opcode, 3'b011);
        check("pre_rst_valid", o_opcode_valid, 1);
        check("pre_rst_row", o_row_idx, 1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("abort_valid", o_opcode_valid, 0);
        check("abort_busy", o_busy, 0);
        check("abort_row", o_row_idx, 0);
        check("abort_layer", o_layer_p, 0);
        @(negedge clk);
        check("abort_stay", o_opcode_valid, 0);
        run_job(2, 6, 4, 2, 1, 1, 1'b0);

        // maximum row count
        run_job(31, 7, 15, 255, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
